// File: rtl/disp_pkg.sv
// Shared types and helpers for the hex display scheduler.
//   state_e  : scheduler FSM states
//   MAX_DISP : largest value the two-digit display can show
//   sat5     : clamps a 6-bit source value onto the 5-bit display range
package disp_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHOW   = 2'd1,
    S_LINGER = 2'd2
  } state_e;

  localparam logic [4:0] MAX_DISP = 5'd31;

  function automatic logic [4:0] sat5(input logic [5:0] v);
    return (v > {1'b0, MAX_DISP}) ? MAX_DISP : v[4:0];
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: index 0 wins.
// Ports:
//   i_req    : request vector
//   o_onehot : one-hot of the lowest set index (all zero when none set)
//   o_idx    : binary index of the lowest set bit (0 when none set)
//   o_valid  : at least one request is set
module prio_enc #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_req[k] && !o_valid) begin
        o_onehot[k] = 1'b1;
        o_idx       = IDX_W'(k);
        o_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Shares one two-digit seven-segment display between N_SRC requesters.
// Fixed priority (index 0 highest), minimum hold time per grant, linger
// of the last value after release, and blink support for the owner.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_req          : level request per source
//   i_val          : 6-bit value per source, source k at [6k+5:6k]
//   i_blink        : per-source blink request (owner's bit only is used)
//   o_hex          : registered, saturated display value
//   o_blank        : force decoder dark
//   o_owner        : current or last owner index
//   o_grant        : one-hot grant, zero outside SHOW
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | nothing to show, display dark
// S_SHOW   | owner granted, o_hex tracks owner value, blink active
// S_LINGER | owner released, last value held on screen for HOLD_CYCLES
module hex_display_scheduler
  import disp_pkg::*;
#(
  parameter int N_SRC        = 3,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_SRC-1:0]   i_req,
  input  logic [6*N_SRC-1:0] i_val,
  input  logic [N_SRC-1:0]   i_blink,
  output logic [4:0]         o_hex,
  output logic               o_blank,
  output logic [1:0]         o_owner,
  output logic [N_SRC-1:0]   o_grant
);

  localparam int IDX_W   = 2;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [4:0]         hex_q, hex_d;
  logic               blank_q, blank_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLINK_W-1:0] blink_q, blink_d;

  logic [N_SRC-1:0] all_oh, hi_oh, hi_req, new_oh;
  logic [IDX_W-1:0] all_idx, hi_idx, new_idx;
  logic             all_valid, hi_valid;
  logic             own_req, own_blink, do_grant;

  function automatic logic [5:0] val_at(input logic [6*N_SRC-1:0] v,
                                        input logic [IDX_W-1:0]   idx);
    logic [5:0] r;
    r = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (idx == IDX_W'(k)) r = v[6*k +: 6];
    end
    return r;
  endfunction

  // Requests strictly higher in priority than the current owner.
  always_comb begin
    hi_req    = '0;
    own_req   = 1'b0;
    own_blink = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      hi_req[k] = i_req[k] && (IDX_W'(k) < owner_q);
      if (owner_q == IDX_W'(k)) begin
        own_req   = i_req[k];
        own_blink = i_blink[k];
      end
    end
  end

  prio_enc #(.N(N_SRC), .IDX_W(IDX_W)) u_enc_all (
    .i_req    (i_req),
    .o_onehot (all_oh),
    .o_idx    (all_idx),
    .o_valid  (all_valid)
  );

  prio_enc #(.N(N_SRC), .IDX_W(IDX_W)) u_enc_hi (
    .i_req    (hi_req),
    .o_onehot (hi_oh),
    .o_idx    (hi_idx),
    .o_valid  (hi_valid)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    hex_d    = hex_q;
    blank_d  = blank_q;
    grant_d  = grant_q;
    hold_d   = hold_q;
    blink_d  = blink_q;
    do_grant = 1'b0;
    new_idx  = all_idx;
    new_oh   = all_oh;

    unique case (state_q)
      S_IDLE: begin
        blank_d = 1'b1;
        grant_d = '0;
        if (all_valid) do_grant = 1'b1;
      end

      S_SHOW: begin
        if (!own_req) begin
          // A release that coincides with a higher request hands over
          // directly; the hold time does not apply to a released owner.
          if (hi_valid) begin
            do_grant = 1'b1;
            new_idx  = hi_idx;
            new_oh   = hi_oh;
          end else begin
            state_d = S_LINGER;
            grant_d = '0;
            hold_d  = '0;
            blink_d = '0;
            blank_d = 1'b0;
          end
        end else if (hi_valid && (hold_q == HOLD_LAST)) begin
          do_grant = 1'b1;
          new_idx  = hi_idx;
          new_oh   = hi_oh;
        end else begin
          if (hold_q != HOLD_LAST) hold_d = hold_q + HOLD_W'(1);
          hex_d = sat5(val_at(i_val, owner_q));
          if (own_blink) begin
            if (blink_q == BLINK_LAST) begin
              blink_d = '0;
              blank_d = ~blank_q;
            end else begin
              blink_d = blink_q + BLINK_W'(1);
            end
          end else begin
            blink_d = '0;
            blank_d = 1'b0;
          end
        end
      end

      S_LINGER: begin
        // Hold counter doubles as the linger timer here.
        if (all_valid) begin
          do_grant = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
          blank_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        blank_d = 1'b1;
        grant_d = '0;
      end
    endcase

    if (do_grant) begin
      state_d = S_SHOW;
      owner_d = new_idx;
      grant_d = new_oh;
      hex_d   = sat5(val_at(i_val, new_idx));
      blank_d = 1'b0;
      hold_d  = '0;
      blink_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      hex_q   <= '0;
      blank_q <= 1'b1;
      grant_q <= '0;
      hold_q  <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
    end
  end

  assign o_hex   = hex_q;
  assign o_blank = blank_q;
  assign o_owner = owner_q;
  assign o_grant = grant_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
module tb_hex_display_scheduler;

  localparam int N_SRC = 3;
  localparam int HOLD  = 8;
  localparam int BLINK = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req   = '0;
  logic [2:0]  blink = '0;
  logic [17:0] val   = '0;
  logic [4:0]  o_hex;
  logic        o_blank;
  logic [1:0]  o_owner;
  logic [2:0]  o_grant;

  always #5 clk = ~clk;

  hex_display_scheduler #(
    .N_SRC        (N_SRC),
    .HOLD_CYCLES  (HOLD),
    .BLINK_CYCLES (BLINK)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_val   (val),
    .i_blink (blink),
    .o_hex   (o_hex),
    .o_blank (o_blank),
    .o_owner (o_owner),
    .o_grant (o_grant)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: mode 0 idle, 1 show, 2 linger. Ages are plain
  // cycle counts; blank phase is derived from how long blink has been held.
  int m_mode = 0, m_owner = 0, m_age = 0, m_lin = 0, m_run = 0;
  int m_hex = 0, m_blank = 1;
  bit started = 0;

  function automatic int lowest(input logic [2:0] r, input int lim);
    for (int k = 0; k < lim; k++) if (r[k]) return k;
    return -1;
  endfunction

  function automatic int sat(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  function automatic int vsel(input int k);
    return int'(val[6*k +: 6]);
  endfunction

  task give(input int k);
    m_mode  = 1;
    m_owner = k;
    m_age   = 0;
    m_run   = 0;
    m_hex   = sat(vsel(k));
    m_blank = 0;
  endtask

  always @(posedge clk) begin
    int all_i, hi_i;
    started = 1;
    if (!rst_n) begin
      m_mode = 0; m_hex = 0; m_blank = 1; m_owner = 0;
      m_age = 0; m_lin = 0; m_run = 0;
    end else begin
      all_i = lowest(req, N_SRC);
      hi_i  = lowest(req, m_owner);
      case (m_mode)
        0: if (all_i >= 0) give(all_i);
        1: begin
          if (!req[m_owner]) begin
            if (hi_i >= 0) give(hi_i);
            else begin m_mode = 2; m_lin = 0; m_blank = 0; end
          end else if (hi_i >= 0 && m_age >= HOLD - 1) begin
            give(hi_i);
          end else begin
            m_age++;
            m_hex = sat(vsel(m_owner));
            if (blink[m_owner]) m_run++; else m_run = 0;
            m_blank = (m_run / BLINK) % 2;
          end
        end
        default: begin
          if (all_i >= 0) give(all_i);
          else begin
            m_lin++;
            if (m_lin == HOLD) begin m_mode = 0; m_blank = 1; end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("hex",   int'(o_hex),   m_hex);
      check("blank", int'(o_blank), m_blank);
      check("owner", int'(o_owner), m_owner);
      check("grant", int'(o_grant), (m_mode == 1) ? (1 << m_owner) : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [11:0] pat;

  initial begin
    pat = 12'b0000_1111_0000;

    // reset then idle
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lit_idle_blank", int'(o_blank), 1);
      check("lit_idle_grant", int'(o_grant), 0);
      check("lit_idle_hex",   int'(o_hex),   0);
    end

    // first grant to source 2, then saturation
    req = 3'b100; val[17:12] = 6'd17;
    tick();
    check("lit_g2_grant", int'(o_grant), 4);
    check("lit_g2_owner", int'(o_owner), 2);
    check("lit_g2_hex",   int'(o_hex),   17);
    check("lit_g2_blank", int'(o_blank), 0);
    val[17:12] = 6'd40;
    tick();
    check("lit_sat_hex", int'(o_hex), 31);

    // preemption waits for the hold time
    tick(); tick();
    req[0] = 1'b1; val[5:0] = 6'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lit_hold_grant", int'(o_grant), 4);
    end
    tick();
    check("lit_pre_grant", int'(o_grant), 1);
    check("lit_pre_hex",   int'(o_hex),   5);

    // owner 1, release, full linger to idle
    req = 3'b010; val[11:6] = 6'd9;
    tick(); tick();
    check("lit_g1_grant", int'(o_grant), 2);
    req = 3'b000;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("lit_lin_grant", int'(o_grant), 0);
      check("lit_lin_hex",   int'(o_hex),   9);
      check("lit_lin_blank", int'(o_blank), 0);
    end
    tick();
    check("lit_lin_idle_blank", int'(o_blank), 1);
    check("lit_lin_idle_owner", int'(o_owner), 1);

    // linger interrupted on its fourth cycle
    req = 3'b010;
    tick();
    req = 3'b000;
    tick(); tick(); tick(); tick();
    req = 3'b100; val[17:12] = 6'd22;
    tick();
    check("lit_lin4_grant", int'(o_grant), 4);
    check("lit_lin4_hex",   int'(o_hex),   22);

    // owner 0 blinking (also a drop with simultaneous higher request)
    req = 3'b001; val[5:0] = 6'd3; blink = 3'b001;
    tick();
    check("lit_b_grant", int'(o_grant), 1);
    check("lit_b_blank0", int'(o_blank), int'(pat[11]));
    for (int i = 1; i < 12; i++) begin
      tick();
      check("lit_b_pattern", int'(o_blank), int'(pat[11-i]));
    end
    tick();
    check("lit_b_blank_on", int'(o_blank), 1);
    tick();
    blink = 3'b000;
    tick();
    check("lit_b_clear", int'(o_blank), 0);

    // reset during blinking show
    blink = 3'b001;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("lit_rst_hex",   int'(o_hex),   0);
    check("lit_rst_blank", int'(o_blank), 1);
    check("lit_rst_owner", int'(o_owner), 0);
    check("lit_rst_grant", int'(o_grant), 0);
    rst_n = 1'b1;
    tick();
    check("lit_regrant", int'(o_grant), 1);
    check("lit_regrant_hex", int'(o_hex), 3);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) req[r] = ~req[r];
      if ($urandom_range(0, 19) == 0) req = 3'($urandom);
      r = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) blink[r] = ~blink[r];
      if ($urandom_range(0, 2) == 0) val = 18'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
- Shares the single two-digit seven-segment display (5-bit value, 0..31, feeding the board's hex decoder) between N_SRC requesters, e.g. record timer, play timer and speed setting in the audio recorder.
- Grants by fixed priority with a minimum-hold time to prevent flicker, and keeps the last value on screen after release.
- Provides blink control for paused states.
- Sits between the recorder/player control logic and the decoder in the DE2_115 top level.

Parameters:
- N_SRC, 3, number of requesters (2..4); index 0 has highest priority.
- HOLD_CYCLES, 50_000_000, minimum display time per grant, and linger time after release (1 s at 50 MHz).
- BLINK_CYCLES, 12_500_000, half-period of the blank toggle while blinking.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous reset, active-low.
- i_req  in  N_SRC  level request per source.
- i_val  in  6*N_SRC  per-source value, 6 bits each; source k occupies bits [6k+5:6k].
- i_blink  in  N_SRC  per-source blink request, sampled only for the current owner.
- o_hex  out  5  value to decoder, registered.
- o_blank  out  1  1 = decoder output must be forced dark.
- o_owner  out  2  index of the current or last owner.
- o_grant  out  N_SRC  one-hot grant; all zero in IDLE and LINGER.

Behaviour:
- Reset (i_rst_n low at a clock edge), regardless of state:
  - state = IDLE; o_hex = 0; o_blank = 1; o_owner = 0; o_grant = 0.
  - Hold and blink counters = 0.
- Saturation: a value above 31 is clamped to 31 before registering.
- Latency: o_hex reflects the owner's i_val one cycle after the edge, and tracks it live while in SHOW.
- IDLE:
  - o_blank = 1.
  - If any i_req is set, go to SHOW with owner = lowest set index.
  - Next cycle: o_grant one-hot, o_blank = 0, hold counter cleared.
- SHOW:
  - Hold counter increments each cycle and saturates at HOLD_CYCLES-1.
  - If the owner's req drops, go to LINGER. o_hex freezes at its last value; the hold counter clears.
  - Preemption: if a higher-priority req is set and the hold counter has reached HOLD_CYCLES-1, switch owner to that index. The hold counter and blink counter clear, and o_blank = 0. Before that point the higher request waits.
  - A lower-priority req never preempts.
  - Simultaneous owner drop and higher-priority request: LINGER is skipped and the new owner is granted immediately. The drop takes precedence over the hold check.
- LINGER:
  - o_grant = 0; o_hex frozen; o_blank = 0.
  - Any req set: grant the highest-priority requester immediately, even the previous owner, with counters cleared.
  - Otherwise, after HOLD_CYCLES cycles go to IDLE.
- Blink (SHOW only):
  - If i_blink[owner] = 1, o_blank toggles every BLINK_CYCLES cycles, starting at 0.
  - When i_blink[owner] = 0, the blink counter clears and o_blank = 0.
  - A change of owner restarts the blink phase at o_blank = 0.
- Counter widths: $clog2(HOLD_CYCLES) and $clog2(BLINK_CYCLES), minimum 1 bit.
- Unused o_owner bits are 0 when N_SRC < 4.

Decomposition:
- Shared package disp_pkg holds:
  - State enum {S_IDLE, S_SHOW, S_LINGER}.
  - Constant MAX_DISP = 31.
  - Function sat5 (6-bit to 5-bit clamp).
- Sub-module prio_enc: N_SRC-bit request to lowest-index one-hot plus index, with a valid flag. It is reused for both IDLE grant and the preemption check (masked to indices below the owner).

Test Plan (sim with HOLD_CYCLES=8, BLINK_CYCLES=4, N_SRC=3):
- Reset held 3 cycles, then released with no requests:
  - o_hex=0, o_blank=1, o_grant=000 throughout.
- req[2]=1 with val=17:
  - Next cycle: o_grant=100, o_owner=2, o_hex=17, o_blank=0.
  - val set to 40: o_hex=31 one cycle later.
- Owner 2 holding; req[0] raised 3 cycles into the grant:
  - o_grant stays 100 until the hold counter reaches 7, then becomes 001.
  - o_hex follows val[0] on the next cycle.
- Owner 1 drops req with no other requests:
  - o_grant=000 and o_hex frozen for 8 cycles, then IDLE with o_blank=1.
  - Repeat with req[2] raised on LINGER cycle 4: grant 100 the next cycle.
- Owner 0 with i_blink[0]=1:
  - o_blank pattern 0000 1111 0000 ...
  - Clearing blink mid-phase gives o_blank=0 the next cycle.
- i_rst_n driven low during SHOW with blink active:
  - Next edge: all outputs at reset values, state IDLE.
  - Requests still asserted after release: regrant after one IDLE cycle.
